str_streamer: RTL and testbench
===============================

# str_streamer

Memory-to-UART string streamer. On a START pulse it reads a NUL-terminated byte string from a synchronous-read BRAM port, beginning at BASE, and hands each non-NUL byte to the UART transmit side over a valid/ready handshake. It sits between the BRAM read port and the UART DIN/RDY pair. It replaces ad-hoc address-stepping glue with a defined FSM that has length limiting and completion reporting.

## Interface
Parameters:
- AddrBits, 19, width of the memory address.
- MaxLen, 255, maximum bytes emitted per string; legal range 1..255.

Ports:
- CLK  in  1  system clock. One clock domain; reset is synchronous and active-high.
- RST  in  1  synchronous active-high reset.
- START  in  1  one-cycle request; sampled only in IDLE.
- BASE  in  AddrBits  string start address; sampled with START.
- MADDR  out  AddrBits  BRAM read address.
- MDATA  in  8  BRAM read data, valid one cycle after MADDR.
- TDATA  out  8  byte to transmit.
- TVALID  out  1  TDATA is valid.
- TREADY  in  1  UART accepts the byte this cycle.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse when a string finishes.
- TRUNC  out  1  set when the last string hit MaxLen without reaching NUL; held until the next START.
- LEN  out  8  bytes emitted by the last string; held until the next START.

## Operation
- States: IDLE, FETCH, LOAD, SEND, FIN.
- IDLE: if START=1, latch MADDR<=BASE, clear LEN and TRUNC, go to FETCH. START is ignored in every other state.
- FETCH: one cycle for the BRAM read; go to LOAD.
- LOAD: TDATA<=MDATA.
  - If MDATA==0, go to FIN and emit nothing.
  - Otherwise set TVALID=1 and go to SEND.
- SEND: hold TVALID and TDATA stable until TREADY=1. On the handshake cycle:
  - TVALID<=0, LEN<=LEN+1, MADDR<=MADDR+1.
  - If LEN+1==MaxLen, set TRUNC=1 and go to FIN. Otherwise go to FETCH.
- FIN: DONE=1 for exactly this cycle, then go to IDLE.
- MADDR increments modulo 2^AddrBits. All-ones wraps to 0, with no error.
- LEN is 8-bit and never exceeds MaxLen, so it never wraps.
- A NUL byte is never presented on TDATA/TVALID.
- TREADY while TVALID=0 has no effect.

## Timing
- Reset values: state=IDLE, MADDR=0, TDATA=0, TVALID=0, BUSY=0, DONE=0, TRUNC=0, LEN=0.
- RST has priority over every other input in every state. It applies mid-transfer, and TVALID falls on the next edge even if TREADY is high in the same cycle. No DONE pulse is produced for an aborted string.
- START at edge n: BUSY=1 and MADDR=BASE from n+1. TVALID for the first byte rises at n+3.
- Per-byte cost is 3 cycles plus TREADY wait: FETCH, LOAD, SEND.
- Empty string (MDATA==0 at BASE): DONE pulses at n+3, the cycle after LOAD. BUSY falls at n+4. TVALID never rises.
- BUSY is low in the cycle after FIN, so START is accepted at that edge.
- Outputs are registered; no combinational path from TREADY to TVALID.

## Structure
- Shared package: state encoding constants (IDLE..FIN, 3-bit) and the NUL terminator constant 8'h00.
- Single flat module; no sub-module is needed. The BRAM and UART stay instantiated at SoC level.
- Integration: TDATA drives UART DIN, and TREADY is derived from UART RDY. MADDR/MDATA connect to the BRAM ADDR/DOUT with WR tied to 0.

## Test plan
- "Hi\0" at BASE=0x10, TREADY tied high: TDATA sequence 0x48, 0x69, each TVALID held 1 cycle. DONE pulses once. LEN=2, TRUNC=0. Final MADDR=0x12.
- Same string with TREADY low for 5 cycles per byte: TVALID and TDATA stay stable throughout the stall. Output bytes are identical.
- Empty string (0x00 at BASE): no TVALID. DONE pulses 3 cycles after START. LEN=0.
- MaxLen=4 over 10 non-NUL bytes: exactly 4 bytes are emitted. TRUNC=1, LEN=4, DONE pulses.
- BASE=all-ones, "A" then "B" at 0 and 0x00 at 1: emits 0x41, 0x42. MADDR wraps to 0.
- RST asserted during SEND with TREADY=1: next cycle TVALID=0, BUSY=0, no DONE. A fresh START streams the string correctly. START pulsed while BUSY is ignored, and LEN is unchanged by it.

Source files
------------

// File: rtl/str_streamer_pkg.sv
// Shared definitions for the memory-to-UART string streamer.
//   state_e : 3-bit FSM state encoding (IDLE, FETCH, LOAD, SEND, FIN)
//   Nul     : string terminator byte
package str_streamer_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StLoad  = 3'd2,
    StSend  = 3'd3,
    StFin   = 3'd4
  } state_e;

  localparam logic [7:0] Nul = 8'h00;

  // True when emitting one more byte reaches the length limit.
  function automatic logic hits_limit(input logic [7:0] len_next, input logic [7:0] max_len);
    return (len_next == max_len);
  endfunction

endpackage

// File: rtl/str_streamer.sv
// Memory-to-UART string streamer.
// On START (sampled in IDLE only) reads a NUL-terminated string from a
// synchronous-read BRAM port starting at BASE and hands every non-NUL byte to
// the UART over a TVALID/TREADY handshake. Emission stops at NUL or after
// MaxLen bytes, whichever comes first.
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   START, BASE   one-cycle request and string start address
//   MADDR, MDATA  BRAM read address / data (data valid one cycle after address)
//   TDATA, TVALID byte to transmit and its valid flag
//   TREADY        UART accepts the byte this cycle
//   BUSY          high in every state except IDLE
//   DONE          one-cycle pulse when a string finishes (not on reset abort)
//   TRUNC, LEN    last-string status, held until the next START
module str_streamer
  import str_streamer_pkg::*;
#(
  parameter int unsigned AddrBits = 19,
  parameter int unsigned MaxLen   = 255
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic [AddrBits-1:0] BASE,
  output logic [AddrBits-1:0] MADDR,
  input  logic [7:0]          MDATA,
  output logic [7:0]          TDATA,
  output logic                TVALID,
  input  logic                TREADY,
  output logic                BUSY,
  output logic                DONE,
  output logic                TRUNC,
  output logic [7:0]          LEN
);

  localparam logic [7:0]          MaxLenB = 8'(MaxLen);
  localparam logic [AddrBits-1:0] AddrOne = AddrBits'(1);

  state_e              r_state;
  logic [AddrBits-1:0] r_maddr;
  logic [7:0]          r_tdata;
  logic                r_tvalid;
  logic                r_busy;
  logic                r_done;
  logic                r_trunc;
  logic [7:0]          r_len;

  logic [7:0]          w_len_inc;

  assign w_len_inc = r_len + 8'd1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= StIdle;
      r_maddr  <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_trunc  <= 1'b0;
      r_len    <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (START) begin
            r_maddr <= BASE;
            r_len   <= '0;
            r_trunc <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= StFetch;
          end
        end
        // Address is already on MADDR; this cycle covers the BRAM read latency.
        StFetch: r_state <= StLoad;
        StLoad: begin
          r_tdata <= MDATA;
          if (MDATA == Nul) begin
            r_done  <= 1'b1;
            r_state <= StFin;
          end else begin
            r_tvalid <= 1'b1;
            r_state  <= StSend;
          end
        end
        StSend: begin
          if (TREADY) begin
            r_tvalid <= 1'b0;
            r_len    <= w_len_inc;
            r_maddr  <= r_maddr + AddrOne;  // wraps modulo 2^AddrBits
            if (hits_limit(w_len_inc, MaxLenB)) begin
              r_trunc <= 1'b1;
              r_done  <= 1'b1;
              r_state <= StFin;
            end else begin
              r_state <= StFetch;
            end
          end
        end
        StFin: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign MADDR  = r_maddr;
  assign TDATA  = r_tdata;
  assign TVALID = r_tvalid;
  assign BUSY   = r_busy;
  assign DONE   = r_done;
  assign TRUNC  = r_trunc;
  assign LEN    = r_len;

endmodule

// File: tb/tb_str_streamer.sv
// Scoreboard bench for str_streamer. Two instances share stimulus: dut_a with
// MaxLen=255 and dut_b with MaxLen=4. Expected bytes are queued per instance
// and popped by a negedge monitor on every accepted handshake.
module tb_str_streamer;

  localparam int AW = 19;

  logic          CLK = 1'b0;
  logic          RST, START, TREADY;
  logic [AW-1:0] BASE;

  logic [AW-1:0] maddr_a, maddr_b;
  logic [7:0]    mdata_a = 8'h00, mdata_b = 8'h00;
  logic [7:0]    tdata_a, tdata_b, len_a, len_b;
  logic          tvalid_a, tvalid_b, busy_a, busy_b, done_a, done_b, trunc_a, trunc_b;

  logic [7:0] mem [int unsigned];
  logic [7:0] qa [$];
  logic [7:0] qb [$];

  int n_tests = 0;
  int n_fail  = 0;
  int vcnt_a  = 0;
  int dcnt_a  = 0;
  int dcnt_b  = 0;

  always #5 CLK = ~CLK;

  str_streamer #(.AddrBits(AW), .MaxLen(255)) dut_a (
    .CLK(CLK), .RST(RST), .START(START), .BASE(BASE), .MADDR(maddr_a), .MDATA(mdata_a),
    .TDATA(tdata_a), .TVALID(tvalid_a), .TREADY(TREADY), .BUSY(busy_a), .DONE(done_a),
    .TRUNC(trunc_a), .LEN(len_a)
  );

  str_streamer #(.AddrBits(AW), .MaxLen(4)) dut_b (
    .CLK(CLK), .RST(RST), .START(START), .BASE(BASE), .MADDR(maddr_b), .MDATA(mdata_b),
    .TDATA(tdata_b), .TVALID(tvalid_b), .TREADY(TREADY), .BUSY(busy_b), .DONE(done_b),
    .TRUNC(trunc_b), .LEN(len_b)
  );

  function automatic logic [7:0] rd(input logic [AW-1:0] a);
    int unsigned k;
    k = 32'(a);
    if (mem.exists(k)) return mem[k];
    return 8'h00;
  endfunction

  // Synchronous-read BRAM models.
  always @(posedge CLK) mdata_a <= rd(maddr_a);
  always @(posedge CLK) mdata_b <= rd(maddr_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start(input logic [AW-1:0] b);
    START = 1'b1;
    BASE  = b;
    tick();
    START = 1'b0;
  endtask

  task automatic monitor();
    logic       pv_a, pr_a, pv_b, pr_b;
    logic [7:0] pd_a, pd_b;
    pv_a = 1'b0; pr_a = 1'b0; pd_a = 8'h00;
    pv_b = 1'b0; pr_b = 1'b0; pd_b = 8'h00;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        if (pv_a && !pr_a) begin
          chk("hold_valid_a", 32'(tvalid_a), 32'd1);
          chk("hold_data_a", 32'(tdata_a), 32'(pd_a));
        end
        if (pv_b && !pr_b) begin
          chk("hold_valid_b", 32'(tvalid_b), 32'd1);
          chk("hold_data_b", 32'(tdata_b), 32'(pd_b));
        end
        if (tvalid_a) vcnt_a++;
        if (done_a) dcnt_a++;
        if (done_b) dcnt_b++;
        if (tvalid_a && TREADY) begin
          if (qa.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL extra_byte_a: got 0x%0h, expected no byte", tdata_a);
          end else chk("byte_a", 32'(tdata_a), 32'(qa.pop_front()));
        end
        if (tvalid_b && TREADY) begin
          if (qb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL extra_byte_b: got 0x%0h, expected no byte", tdata_b);
          end else chk("byte_b", 32'(tdata_b), 32'(qb.pop_front()));
        end
      end
      pv_a = tvalid_a && !RST; pr_a = TREADY; pd_a = tdata_a;
      pv_b = tvalid_b && !RST; pr_b = TREADY; pd_b = tdata_b;
    end
  endtask

  // stall=0: TREADY high throughout; otherwise TREADY held low for 'stall'
  // cycles of each TVALID, then high for one. Ends one cycle after dut_a DONE.
  task automatic run(input int stall, input string tag);
    int wcnt;
    bit got;
    wcnt = 0;
    got  = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      if (stall == 0) TREADY = 1'b1;
      else if (tvalid_a) begin
        if (wcnt == stall) begin
          TREADY = 1'b1;
          wcnt   = 0;
        end else begin
          TREADY = 1'b0;
          wcnt++;
        end
      end else TREADY = 1'b0;
      tick();
      if (done_a) got = 1'b1;
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: DONE not seen, required within 400 cycles", tag);
    end
    tick();
    chk({tag, "_busy_low"}, 32'(busy_a), 32'd0);
  endtask

  initial begin
    int d0, db0, v0;
    bit seen;

    RST = 1'b1; START = 1'b0; BASE = '0; TREADY = 1'b0;
    mem[32'h10] = 8'h48; mem[32'h11] = 8'h69; mem[32'h12] = 8'h00;
    mem[32'h40] = 8'h00;
    for (int i = 0; i < 10; i++) mem[32'h100 + i] = 8'(8'h30 + i);
    mem[32'h10A] = 8'h00;
    mem[32'h7FFFF] = 8'h41; mem[32'h0] = 8'h42; mem[32'h1] = 8'h00;

    fork
      monitor();
    join_none

    repeat (3) tick();
    chk("rst_maddr", 32'(maddr_a), 32'd0);
    chk("rst_tdata", 32'(tdata_a), 32'd0);
    chk("rst_tvalid", 32'(tvalid_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_trunc", 32'(trunc_a), 32'd0);
    chk("rst_len", 32'(len_a), 32'd0);
    RST = 1'b0;
    tick();

    // "Hi" with TREADY tied high.
    qa.push_back(8'h48); qa.push_back(8'h69);
    qb.push_back(8'h48); qb.push_back(8'h69);
    d0 = dcnt_a; v0 = vcnt_a;
    TREADY = 1'b1;
    start(19'h10);
    chk("hi_busy_n1", 32'(busy_a), 32'd1);
    chk("hi_maddr_n1", 32'(maddr_a), 32'h10);
    tick();
    chk("hi_tvalid_n2", 32'(tvalid_a), 32'd0);
    tick();
    chk("hi_tvalid_n3", 32'(tvalid_a), 32'd1);
    chk("hi_tdata_n3", 32'(tdata_a), 32'h48);
    run(0, "hi");
    chk("hi_len", 32'(len_a), 32'd2);
    chk("hi_trunc", 32'(trunc_a), 32'd0);
    chk("hi_maddr", 32'(maddr_a), 32'h12);
    chk("hi_done_cnt", 32'(dcnt_a - d0), 32'd1);
    chk("hi_valid_cycles", 32'(vcnt_a - v0), 32'd2);

    // Empty string.
    TREADY = 1'b0;
    d0 = dcnt_a; v0 = vcnt_a;
    start(19'h40);
    chk("empty_busy_n1", 32'(busy_a), 32'd1);
    tick();
    chk("empty_done_n2", 32'(done_a), 32'd0);
    tick();
    chk("empty_done_n3", 32'(done_a), 32'd1);
    tick();
    chk("empty_busy_n4", 32'(busy_a), 32'd0);
    chk("empty_done_n4", 32'(done_a), 32'd0);
    chk("empty_len", 32'(len_a), 32'd0);
    chk("empty_no_valid", 32'(vcnt_a - v0), 32'd0);
    chk("empty_done_cnt", 32'(dcnt_a - d0), 32'd1);

    // "Hi" with 5-cycle stalls per byte.
    qa.push_back(8'h48); qa.push_back(8'h69);
    qb.push_back(8'h48); qb.push_back(8'h69);
    start(19'h10);
    run(5, "stall");
    chk("stall_len", 32'(len_a), 32'd2);
    chk("stall_trunc", 32'(trunc_a), 32'd0);

    // Ten bytes: dut_a emits all, dut_b truncates at 4.
    for (int i = 0; i < 10; i++) qa.push_back(8'(8'h30 + i));
    for (int i = 0; i < 4; i++) qb.push_back(8'(8'h30 + i));
    db0 = dcnt_b;
    start(19'h100);
    run(0, "long");
    chk("long_len_a", 32'(len_a), 32'd10);
    chk("long_trunc_a", 32'(trunc_a), 32'd0);
    chk("long_maddr_a", 32'(maddr_a), 32'h10A);
    chk("trunc_len_b", 32'(len_b), 32'd4);
    chk("trunc_trunc_b", 32'(trunc_b), 32'd1);
    chk("trunc_maddr_b", 32'(maddr_b), 32'h104);
    chk("trunc_done_cnt_b", 32'(dcnt_b - db0), 32'd1);
    chk("trunc_busy_b", 32'(busy_b), 32'd0);

    // Address wrap from all-ones.
    qa.push_back(8'h41); qa.push_back(8'h42);
    qb.push_back(8'h41); qb.push_back(8'h42);
    start(19'h7FFFF);
    run(0, "wrap");
    chk("wrap_len", 32'(len_a), 32'd2);
    chk("wrap_maddr", 32'(maddr_a), 32'h1);

    // Reset during SEND with TREADY high.
    TREADY = 1'b0;
    d0 = dcnt_a;
    start(19'h10);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (tvalid_a) seen = 1'b1;
      else tick();
    end
    chk("rst_mid_tvalid_seen", 32'(seen), 32'd1);
    TREADY = 1'b1;
    RST    = 1'b1;
    tick();
    chk("rst_mid_tvalid", 32'(tvalid_a), 32'd0);
    chk("rst_mid_busy", 32'(busy_a), 32'd0);
    chk("rst_mid_done", 32'(done_a), 32'd0);
    RST    = 1'b0;
    TREADY = 1'b0;
    tick();
    tick();
    chk("rst_mid_no_done", 32'(dcnt_a - d0), 32'd0);

    // Fresh START after abort, with a START pulse while BUSY that must be ignored.
    qa.push_back(8'h48); qa.push_back(8'h69);
    qb.push_back(8'h48); qb.push_back(8'h69);
    d0 = dcnt_a;
    TREADY = 1'b1;
    start(19'h10);
    start(19'h40);
    run(0, "restart");
    chk("restart_len", 32'(len_a), 32'd2);
    chk("restart_done_cnt", 32'(dcnt_a - d0), 32'd1);
    tick();
    tick();
    chk("ignored_start_busy", 32'(busy_a), 32'd0);
    chk("ignored_start_len", 32'(len_a), 32'd2);

    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
